// File: rtl/osiris_pkg.sv
// ============================================================================
//  Module      : osiris_pkg
//  Description : Shared definitions for the memory-port arbiter: FSM state
//                encoding, bridge bank-decode field positions and bank limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osiris_pkg;

    // Upper bound on the number of memory banks the bridge can address
    localparam int MAX_BANKS = 8;

    // Width of the bank-select field in the bridge byte address
    localparam int c_BANK_SEL_W = $clog2(MAX_BANKS);

    // Bridge addresses are byte addresses; word index starts at bit 2
    localparam int c_WORD_LSB = 2;

    // Bridge-side transaction states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_bank_port.sv
// ============================================================================
//  Module      : wb_bank_port
//  Description : Per-bank multiplexer choosing between the core's direct port
//                and the latched bridge access. Holds the bank idle and the
//                core stalled while the block is in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bank_port #(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_AW    = 10
) (
    input  logic                  i_hold,
    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [BANK_AW-1:0]    i_core_adr,
    input  logic [DATA_WIDTH-1:0] i_core_dat,
    input  logic                  i_br_own,
    input  logic                  i_br_we,
    input  logic [BANK_AW-1:0]    i_br_adr,
    input  logic [DATA_WIDTH-1:0] i_br_dat,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [BANK_AW-1:0]    o_mem_adr,
    output logic [DATA_WIDTH-1:0] o_mem_wdat,
    output logic                  o_core_stall
);

    // Core passes straight through unless held in reset or the bridge owns the bank
    always_comb begin
        o_mem_en     = i_core_req;
        o_mem_we     = i_core_we;
        o_mem_adr    = i_core_adr;
        o_mem_wdat   = i_core_dat;
        o_core_stall = 1'b0;
        if (i_hold) begin
            o_mem_en     = 1'b0;
            o_mem_we     = 1'b0;
            o_core_stall = 1'b1;
        end else if (i_br_own) begin
            o_mem_en     = 1'b1;
            o_mem_we     = i_br_we;
            o_mem_adr    = i_br_adr;
            o_mem_wdat   = i_br_dat;
            o_core_stall = i_core_req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
// ============================================================================
//  Module      : wb_mem_arbiter
//  Description : Shares NUM_BANKS memory banks between the core's direct ports
//                and a Wishbone classic bridge master. The core has priority;
//                after MAX_WAIT denied cycles the bridge takes the bank for
//                one cycle and the core is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_arbiter
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_AW    = 10,
    parameter int MAX_WAIT   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_BANKS-1:0]            i_core_req,
    input  logic [NUM_BANKS-1:0]            i_core_we,
    input  logic [NUM_BANKS*BANK_AW-1:0]    i_core_adr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_core_dat,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_core_dat,
    output logic [NUM_BANKS-1:0]            o_core_stall,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
    output logic [DATA_WIDTH-1:0]           wbs_dat_o,
    output logic                            wbs_ack_o,
    output logic [NUM_BANKS-1:0]            o_mem_en,
    output logic [NUM_BANKS-1:0]            o_mem_we,
    output logic [NUM_BANKS*BANK_AW-1:0]    o_mem_adr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_mem_wdat,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_mem_rdat
);

    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t                r_state;
    logic [c_WAIT_W-1:0]       r_wait;
    logic [c_BANK_SEL_W-1:0]   r_bank;
    logic [BANK_AW-1:0]        r_word;
    logic                      r_we;
    logic [DATA_WIDTH-1:0]     r_wdat;
    logic                      r_ack;
    logic [DATA_WIDTH-1:0]     r_dat;

    logic [c_BANK_SEL_W-1:0]   w_req_bank;
    logic [BANK_AW-1:0]        w_req_word;
    logic                      w_bank_ok;
    logic [NUM_BANKS-1:0]      w_bank_sel;
    logic [NUM_BANKS-1:0]      w_own;
    logic                      w_core_req_sel;
    logic                      w_grant;
    logic [DATA_WIDTH-1:0]     w_rdat_sel;
    logic                      w_unused_adr;

    assign w_req_word   = wbs_adr_i[c_WORD_LSB +: BANK_AW];
    assign w_req_bank   = wbs_adr_i[BANK_AW + c_WORD_LSB +: c_BANK_SEL_W];
    assign w_bank_ok    = (int'(w_req_bank) < NUM_BANKS);
    // Only the word and bank fields are decoded; remaining address bits are ignored
    assign w_unused_adr = ^wbs_adr_i;

    assign w_core_req_sel = |(i_core_req & w_bank_sel);
    // Bridge wins when the core is idle on its bank or has starved it long enough
    assign w_grant = (r_state == ST_ARB) && wbs_cyc_i &&
                     (!w_core_req_sel || (r_wait == c_WAIT_W'(MAX_WAIT)));

    assign o_core_dat = i_mem_rdat;
    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;

    // Select the read data of the bank the bridge is working on
    always_comb begin
        w_rdat_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_sel[b]) begin
                w_rdat_sel = i_mem_rdat[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_bank_sel[b] = (r_bank == c_BANK_SEL_W'(b));
            assign w_own[b]      = w_grant && w_bank_sel[b];

            wb_bank_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .BANK_AW    (BANK_AW)
            ) u_port (
                .i_hold       (!rst),
                .i_core_req   (i_core_req[b]),
                .i_core_we    (i_core_we[b]),
                .i_core_adr   (i_core_adr[b*BANK_AW +: BANK_AW]),
                .i_core_dat   (i_core_dat[b*DATA_WIDTH +: DATA_WIDTH]),
                .i_br_own     (w_own[b]),
                .i_br_we      (r_we),
                .i_br_adr     (r_word),
                .i_br_dat     (r_wdat),
                .o_mem_en     (o_mem_en[b]),
                .o_mem_we     (o_mem_we[b]),
                .o_mem_adr    (o_mem_adr[b*BANK_AW +: BANK_AW]),
                .o_mem_wdat   (o_mem_wdat[b*DATA_WIDTH +: DATA_WIDTH]),
                .o_core_stall (o_core_stall[b])
            );
        end
    endgenerate

    // Bridge transaction FSM with starvation counter and registered ack/data
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_bank  <= '0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_wdat  <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        r_bank <= w_req_bank;
                        r_word <= w_req_word;
                        r_we   <= wbs_we_i;
                        r_wdat <= wbs_dat_i;
                        if (w_bank_ok) begin
                            r_state <= ST_ARB;
                        end else begin
                            // Unmapped bank: answer at once with zero, drop any write
                            r_dat   <= '0;
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end
                    end
                end
                ST_ARB: begin
                    if (!wbs_cyc_i) begin
                        r_wait  <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_grant) begin
                        r_wait <= '0;
                        if (r_we) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_RDATA;
                        end
                    end else if (r_wait != c_WAIT_W'(MAX_WAIT)) begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                ST_RDATA: begin
                    if (!wbs_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dat   <= w_rdat_sel;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_wb_mem_arbiter
//  Description : Self-checking bench for wb_mem_arbiter with a bank memory
//                model and transaction-level expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NB  = 2;
    localparam int BAW = 10;
    localparam int MW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NB-1:0]     core_req, core_we, core_stall;
    logic [NB*BAW-1:0] core_adr;
    logic [NB*DW-1:0]  core_dat, core_rdat;
    logic              cyc, stb, we, ack;
    logic [AW-1:0]     adr;
    logic [DW-1:0]     wdat, dat_o;
    logic [NB-1:0]     mem_en, mem_we;
    logic [NB*BAW-1:0] mem_adr;
    logic [NB*DW-1:0]  mem_wdat, mem_rdat;

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BANKS (NB),
        .BANK_AW (BAW), .MAX_WAIT (MW)
    ) dut (
        .clk (clk), .rst (rst),
        .i_core_req (core_req), .i_core_we (core_we), .i_core_adr (core_adr),
        .i_core_dat (core_dat), .o_core_dat (core_rdat), .o_core_stall (core_stall),
        .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we), .wbs_adr_i (adr),
        .wbs_dat_i (wdat), .wbs_dat_o (dat_o), .wbs_ack_o (ack),
        .o_mem_en (mem_en), .o_mem_we (mem_we), .o_mem_adr (mem_adr),
        .o_mem_wdat (mem_wdat), .i_mem_rdat (mem_rdat)
    );

    // Physical bank memories answering the DUT, read latency one cycle
    logic [DW-1:0] phys [NB][1<<BAW];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!rst) begin
                for (int w = 0; w < (1<<BAW); w++) phys[b][w] <= '0;
                mem_rdat[b*DW +: DW] <= '0;
            end else if (mem_en[b]) begin
                if (mem_we[b]) phys[b][mem_adr[b*BAW +: BAW]] <= mem_wdat[b*DW +: DW];
                else mem_rdat[b*DW +: DW] <= phys[b][mem_adr[b*BAW +: BAW]];
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Expectations for the current cycle, set by the stimulus
    logic [NB-1:0]  exp_own;
    logic           exp_bwe;
    logic [BAW-1:0] exp_badr;
    logic [DW-1:0]  exp_bdat;
    logic           exp_ack, exp_dat_chk, exp_regs_reset;
    logic [DW-1:0]  exp_dat;

    // Reference memory contents as the specification says they must evolve
    logic [DW-1:0] model [NB][1<<BAW];
    logic [NB-1:0] crd_v;
    logic [DW-1:0] crd_val [NB];
    int stall_cnt = 0, en_cnt = 0, ack_cnt = 0, last_ack_cyc = -1;
    logic [DW-1:0] last_ack_dat;

    // Per-cycle comparison of DUT outputs against the model
    initial begin
        crd_v = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_mem_en", 64'(mem_en), 64'(0));
                chk("rst_mem_we", 64'(mem_we), 64'(0));
                chk("rst_stall", 64'(core_stall), 64'({NB{1'b1}}));
                if (exp_regs_reset) begin
                    chk("rst_ack", 64'(ack), 64'(0));
                    chk("rst_dat_o", 64'(dat_o), 64'(0));
                end
                crd_v = '0;
                for (int b = 0; b < NB; b++)
                    for (int w = 0; w < (1<<BAW); w++) model[b][w] = '0;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    logic          e_en, e_we;
                    logic [BAW-1:0] e_adr;
                    logic [DW-1:0]  e_wd;
                    e_en  = exp_own[b] | core_req[b];
                    e_we  = exp_own[b] ? exp_bwe  : core_we[b];
                    e_adr = exp_own[b] ? exp_badr : core_adr[b*BAW +: BAW];
                    e_wd  = exp_own[b] ? exp_bdat : core_dat[b*DW +: DW];
                    if (crd_v[b]) chk("core_rdat", 64'(core_rdat[b*DW +: DW]), 64'(crd_val[b]));
                    chk("mem_en", 64'(mem_en[b]), 64'(e_en));
                    chk("core_stall", 64'(core_stall[b]), 64'(exp_own[b] & core_req[b]));
                    if (e_en) begin
                        chk("mem_we", 64'(mem_we[b]), 64'(e_we));
                        chk("mem_adr", 64'(mem_adr[b*BAW +: BAW]), 64'(e_adr));
                        if (e_we) chk("mem_wdat", 64'(mem_wdat[b*DW +: DW]), 64'(e_wd));
                    end
                    crd_v[b]   = !exp_own[b] && core_req[b] && !core_we[b];
                    crd_val[b] = model[b][e_adr];
                    if (e_en && e_we) model[b][e_adr] = e_wd;
                    stall_cnt += int'(core_stall[b]);
                    en_cnt    += int'(mem_en[b]);
                end
                chk("wbs_ack", 64'(ack), 64'(exp_ack));
                if (exp_ack && exp_dat_chk) chk("wbs_dat", 64'(dat_o), 64'(exp_dat));
                if (ack) begin
                    ack_cnt++;
                    last_ack_cyc = cyc_cnt;
                    last_ack_dat = dat_o;
                end
            end
        end
    end

    task automatic clear_cycle();
        core_req = '0; core_we = '0; core_adr = '0; core_dat = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        exp_own = '0; exp_bwe = 1'b0; exp_badr = '0; exp_bdat = '0;
        exp_ack = 1'b0; exp_dat_chk = 1'b0; exp_dat = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            clear_cycle();
            step();
        end
    endtask

    // One bridge transaction; core requests the target bank in relative
    // cycles 1..busy; drop_at >= 0 lowers cyc in that cycle and ends there.
    task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input int busy, input int drop_at, output int rel);
        int bank, word, g, last, t0, acks0;
        bit valid;
        bank  = int'(a[BAW+2 +: 3]);
        word  = int'(a[2 +: BAW]);
        valid = (bank < NB);
        g     = 1 + ((busy < MW) ? busy : MW);
        if (!valid) last = 1;
        else if (w) last = g + 1;
        else        last = g + 2;
        if (drop_at >= 0) last = drop_at;
        t0    = cyc_cnt;
        acks0 = ack_cnt;
        for (int k = 0; k <= last; k++) begin
            clear_cycle();
            cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
            if (k == drop_at) begin
                cyc = 1'b0; stb = 1'b0;
            end
            if (valid && k >= 1 && k <= busy) begin
                core_req[bank] = 1'b1;
                core_adr[bank*BAW +: BAW] = BAW'(k);
            end
            if (drop_at < 0) begin
                if (valid && k == g) begin
                    exp_own[bank] = 1'b1;
                    exp_bwe  = w;
                    exp_badr = BAW'(word);
                    exp_bdat = d;
                end
                if (k == last) begin
                    exp_ack     = 1'b1;
                    exp_dat_chk = !(valid && w);
                    exp_dat     = valid ? model[bank][word] : '0;
                end
            end
            step();
        end
        rel = (ack_cnt != acks0) ? (last_ack_cyc - t0) : -1;
    endtask

    initial begin
        int rel, s0, e0, a0;
        exp_regs_reset = 1'b1;
        rst = 1'b0;
        clear_cycle();
        repeat (3) step();
        rst = 1'b1;
        exp_regs_reset = 1'b0;
        idle(1);

        // Core-only traffic: write both banks, read them back
        clear_cycle();
        core_req = 2'b11; core_we = 2'b11;
        core_adr = {10'd7, 10'd1};
        core_dat = {32'hA5A5_0001, 32'h1234_5678};
        step();
        clear_cycle();
        core_req = 2'b11; core_adr = {10'd7, 10'd1};
        step();
        clear_cycle();
        chk("lit_core_rd_b0", 64'(core_rdat[31:0]), 64'h1234_5678);
        chk("lit_core_rd_b1", 64'(core_rdat[63:32]), 64'hA5A5_0001);
        step();

        // Uncontended bridge write to bank 1 word 2
        s0 = stall_cnt;
        run_txn(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 0, -1, rel);
        chk("lit_wr_ack_cycle", 64'(rel), 64'(2));
        chk("lit_wr_mem", 64'(phys[1][2]), 64'hDEAD_BEEF);
        chk("lit_wr_no_stall", 64'(stall_cnt - s0), 64'(0));

        // Back-to-back uncontended read of bank 0 word 1
        run_txn(32'h0000_0004, 1'b0, 32'h0, 0, -1, rel);
        chk("lit_rd_ack_cycle", 64'(rel), 64'(3));
        chk("lit_rd_data", 64'(last_ack_dat), 64'h1234_5678);
        idle(1);

        // Core hammers bank 1 while the bridge writes it: starvation limit
        s0 = stall_cnt;
        run_txn(32'h0000_1010, 1'b1, 32'h0BAD_F00D, 20, -1, rel);
        chk("lit_starve_ack_cycle", 64'(rel), 64'(MW + 2));
        chk("lit_starve_stall_cycles", 64'(stall_cnt - s0), 64'(1));
        chk("lit_starve_mem", 64'(phys[1][4]), 64'h0BAD_F00D);
        idle(1);

        // Short contention on a read of bank 0
        run_txn(32'h0000_0004, 1'b0, 32'h0, 2, -1, rel);
        chk("lit_short_contend_rd", 64'(rel), 64'(5));
        chk("lit_short_contend_dat", 64'(last_ack_dat), 64'h1234_5678);
        idle(1);

        // Unmapped bank 5
        e0 = en_cnt;
        run_txn(32'h0000_5000, 1'b1, 32'hFFFF_FFFF, 0, -1, rel);
        chk("lit_badbank_ack_cycle", 64'(rel), 64'(1));
        chk("lit_badbank_dat", 64'(last_ack_dat), 64'(0));
        chk("lit_badbank_no_en", 64'(en_cnt - e0), 64'(0));

        // cyc dropped while denied in ARB, then immediate new request
        a0 = ack_cnt;
        run_txn(32'h0000_1014, 1'b1, 32'hCAFE_F00D, 20, 4, rel);
        chk("lit_drop_no_ack", 64'(ack_cnt - a0), 64'(0));
        chk("lit_drop_no_write", 64'(phys[1][5]), 64'(0));
        run_txn(32'h0000_1018, 1'b1, 32'h600D_CAFE, 0, -1, rel);
        chk("lit_after_drop_ack", 64'(rel), 64'(2));
        idle(1);

        // Reset asserted while the FSM is in RDATA
        clear_cycle();
        cyc = 1'b1; stb = 1'b1; adr = 32'h0000_1008;
        step();
        clear_cycle();
        cyc = 1'b1; stb = 1'b1; adr = 32'h0000_1008;
        exp_own[1] = 1'b1; exp_badr = 10'd2;
        step();
        clear_cycle();
        rst = 1'b0;
        step();
        exp_regs_reset = 1'b1;
        chk("lit_rst_rdata_dat", 64'(dat_o), 64'(0));
        chk("lit_rst_rdata_ack", 64'(ack), 64'(0));
        chk("lit_rst_rdata_en", 64'(mem_en), 64'(0));
        chk("lit_rst_rdata_stall", 64'(core_stall), 64'(2'b11));
        step();
        rst = 1'b1;
        exp_regs_reset = 1'b0;
        idle(1);
        run_txn(32'h0000_1008, 1'b1, 32'h1111_2222, 0, -1, rel);
        chk("lit_post_rst_ack", 64'(rel), 64'(2));
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
